mac_tx_arbiter: RTL and testbench

Shares the single MAC transmit path between the ARP transmitter and the IP-layer transmitter, which already merges UDP and ICMP. The block grants one requester at a time and forwards the granted byte stream to the MAC framer. It tags each frame with its EtherType and holds off for an inter-frame gap. A watchdog recovers the path if a frame never completes. The block sits between arp_tx / ip_tx and mac_tx.

---
 rtl/mac_tx_pkg.sv | 31 +++
 rtl/mac_tx_arbiter_if.sv | 38 +++
 rtl/mac_tx_watchdog.sv | 37 +++
 rtl/mac_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_tx_pkg.sv
// Shared definitions for the MAC transmit arbiter: EtherTypes, one-hot
// state encodings and the round-robin grant marker.
package mac_tx_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;

    localparam int unsigned STATE_W = 6;

    localparam logic [STATE_W-1:0] ST_IDLE_OH     = 6'b000001;
    localparam logic [STATE_W-1:0] ST_ARP_WAIT_OH = 6'b000010;
    localparam logic [STATE_W-1:0] ST_ARP_OH      = 6'b000100;
    localparam logic [STATE_W-1:0] ST_IP_WAIT_OH  = 6'b001000;
    localparam logic [STATE_W-1:0] ST_IP_OH       = 6'b010000;
    localparam logic [STATE_W-1:0] ST_GAP_OH      = 6'b100000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = ST_IDLE_OH,
        ST_ARP_WAIT = ST_ARP_WAIT_OH,
        ST_ARP      = ST_ARP_OH,
        ST_IP_WAIT  = ST_IP_WAIT_OH,
        ST_IP       = ST_IP_OH,
        ST_GAP      = ST_GAP_OH
    } state_e;

    typedef enum logic {
        GRANT_ARP = 1'b0,
        GRANT_IP  = 1'b1
    } grant_e;

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Bundle of the two requester streams and the MAC framer handshake.
// The arbiter takes the slave view; requesters and framer take master.
interface mac_tx_arbiter_if;

    logic        arp_tx_req;
    logic        arp_tx_ready;
    logic [7:0]  arp_tx_data;
    logic        arp_tx_ack;

    logic        ip_tx_req;
    logic        ip_tx_ready;
    logic [7:0]  ip_tx_data;
    logic        ip_tx_ack;

    logic        mac_tx_req;
    logic        mac_tx_ack;
    logic        mac_send_end;
    logic        mac_tx_ready;
    logic [7:0]  mac_tx_data;
    logic [15:0] mac_frame_type;

    modport slave (
        input  arp_tx_req, arp_tx_ready, arp_tx_data,
        input  ip_tx_req, ip_tx_ready, ip_tx_data,
        input  mac_tx_ack, mac_send_end,
        output arp_tx_ack, ip_tx_ack,
        output mac_tx_req, mac_tx_ready, mac_tx_data, mac_frame_type
    );

    modport master (
        output arp_tx_req, arp_tx_ready, arp_tx_data,
        output ip_tx_req, ip_tx_ready, ip_tx_data,
        output mac_tx_ack, mac_send_end,
        input  arp_tx_ack, ip_tx_ack,
        input  mac_tx_req, mac_tx_ready, mac_tx_data, mac_frame_type
    );

endinterface

// File: rtl/mac_tx_watchdog.sv
// Grant watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1.
module mac_tx_watchdog #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] CNT_LAST = TIMEOUT_CYCLES - 16'd1;

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mac_tx_arbiter.sv
// Round-robin arbiter sharing the MAC transmit path between ARP and IP,
// with EtherType tagging, an inter-frame gap and a per-grant watchdog.
module mac_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF,
    parameter int unsigned IFG_CYCLES     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    mac_tx_arbiter_if.slave   bus
);

    import mac_tx_pkg::*;

    // A zero gap would let a new grant start in the cycle the old one ends.
    localparam int unsigned IFG_EFF  = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
    localparam logic [15:0] IFG_LAST = 16'(IFG_EFF - 1);

    state_e      state_q,          state_d;
    grant_e      last_grant_q,     last_grant_d;
    logic [15:0] gap_cnt_q,        gap_cnt_d;

    logic        mac_tx_req_q,     mac_tx_req_d;
    logic        arp_tx_ack_q,     arp_tx_ack_d;
    logic        ip_tx_ack_q,      ip_tx_ack_d;
    logic        mac_tx_ready_q,   mac_tx_ready_d;
    logic [7:0]  mac_tx_data_q,    mac_tx_data_d;
    logic [15:0] mac_frame_type_q, mac_frame_type_d;

    logic        wd_clr;
    logic        wd_en;
    logic        wd_expired;

    mac_tx_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = 16'd0;

        case (state_q)
            ST_IDLE: begin
                // On a tie ARP wins unless it was the last one served.
                if (bus.arp_tx_req && (!bus.ip_tx_req || (last_grant_q == GRANT_IP))) begin
                    state_d      = ST_ARP_WAIT;
                    last_grant_d = GRANT_ARP;
                end else if (bus.ip_tx_req) begin
                    state_d      = ST_IP_WAIT;
                    last_grant_d = GRANT_IP;
                end
            end
            ST_ARP_WAIT: begin
                if (wd_expired) begin
                    state_d = ST_GAP;
                end else if (bus.mac_tx_ack) begin
                    state_d = ST_ARP;
                end
            end
            ST_ARP: begin
                if (bus.mac_send_end || wd_expired) begin
                    state_d = ST_GAP;
                end
            end
            ST_IP_WAIT: begin
                if (wd_expired) begin
                    state_d = ST_GAP;
                end else if (bus.mac_tx_ack) begin
                    state_d = ST_IP;
                end
            end
            ST_IP: begin
                if (bus.mac_send_end || wd_expired) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wd_en  = (state_q == ST_ARP_WAIT) || (state_q == ST_ARP) ||
                 (state_q == ST_IP_WAIT)  || (state_q == ST_IP);
        // The data phase gets its own full timeout budget.
        wd_clr = !wd_en ||
                 ((state_q == ST_ARP_WAIT) && (state_d == ST_ARP)) ||
                 ((state_q == ST_IP_WAIT)  && (state_d == ST_IP));

        mac_tx_req_d     = (state_q == ST_ARP_WAIT) || (state_q == ST_IP_WAIT);
        arp_tx_ack_d     = (state_q == ST_ARP);
        ip_tx_ack_d      = (state_q == ST_IP);
        mac_frame_type_d = ((state_q == ST_ARP_WAIT) || (state_q == ST_ARP)) ?
                           ETH_TYPE_ARP : ETH_TYPE_IP;
        mac_tx_ready_d   = 1'b0;
        mac_tx_data_d    = 8'h00;
        if (state_q == ST_ARP) begin
            mac_tx_ready_d = bus.arp_tx_ready;
            mac_tx_data_d  = bus.arp_tx_data;
        end else if (state_q == ST_IP) begin
            mac_tx_ready_d = bus.ip_tx_ready;
            mac_tx_data_d  = bus.ip_tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            last_grant_q     <= GRANT_IP;
            gap_cnt_q        <= 16'd0;
            mac_tx_req_q     <= 1'b0;
            arp_tx_ack_q     <= 1'b0;
            ip_tx_ack_q      <= 1'b0;
            mac_tx_ready_q   <= 1'b0;
            mac_tx_data_q    <= 8'h00;
            mac_frame_type_q <= ETH_TYPE_IP;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            gap_cnt_q        <= gap_cnt_d;
            mac_tx_req_q     <= mac_tx_req_d;
            arp_tx_ack_q     <= arp_tx_ack_d;
            ip_tx_ack_q      <= ip_tx_ack_d;
            mac_tx_ready_q   <= mac_tx_ready_d;
            mac_tx_data_q    <= mac_tx_data_d;
            mac_frame_type_q <= mac_frame_type_d;
        end
    end

    assign bus.mac_tx_req     = mac_tx_req_q;
    assign bus.arp_tx_ack     = arp_tx_ack_q;
    assign bus.ip_tx_ack      = ip_tx_ack_q;
    assign bus.mac_tx_ready   = mac_tx_ready_q;
    assign bus.mac_tx_data    = mac_tx_data_q;
    assign bus.mac_frame_type = mac_frame_type_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: a cycle table for arbitration and
// data muxing, plus sequences for latency, gap, watchdog and reset cases.
module tb_mac_tx_arbiter;

    typedef struct packed {
        logic        req;
        logic        arp_ack;
        logic        ip_ack;
        logic        rdy;
        logic [7:0]  data;
        logic [15:0] ftype;
    } out_t;

    typedef struct {
        int         rep;
        logic       arp_req;
        logic       ip_req;
        logic       ack;
        logic       send_end;
        logic       arp_rdy;
        logic [7:0] arp_d;
        logic       ip_rdy;
        logic [7:0] ip_d;
        out_t       exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t vq[$];

    mac_tx_arbiter_if bus ();

    mac_tx_arbiter #(
        .TIMEOUT_CYCLES (16'd100),
        .IFG_CYCLES     (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic out_t mk(input logic r, input logic aa, input logic ia,
                                input logic rd, input logic [7:0] d, input logic [15:0] ft);
        out_t o;
        o.req = r; o.arp_ack = aa; o.ip_ack = ia; o.rdy = rd; o.data = d; o.ftype = ft;
        return o;
    endfunction

    function automatic out_t cur_out();
        return mk(bus.mac_tx_req, bus.arp_tx_ack, bus.ip_tx_ack,
                  bus.mac_tx_ready, bus.mac_tx_data, bus.mac_frame_type);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.arp_tx_req = 0; bus.arp_tx_ready = 0; bus.arp_tx_data = 8'h00;
        bus.ip_tx_req = 0;  bus.ip_tx_ready = 0;  bus.ip_tx_data = 8'h00;
        bus.mac_tx_ack = 0; bus.mac_send_end = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycles until mac_tx_req is seen high; -1 if it never comes.
    task automatic wait_req(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.mac_tx_req) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_ack(input bit is_ip, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((is_ip && bus.ip_tx_ack) || (!is_ip && bus.arp_tx_ack)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic add(input int rep, input logic ar, input logic ir, input logic ak,
                       input logic se, input logic ardy, input logic [7:0] ad,
                       input logic irdy, input logic [7:0] id, input out_t e);
        vec_t v;
        v.rep = rep; v.arp_req = ar; v.ip_req = ir; v.ack = ak; v.send_end = se;
        v.arp_rdy = ardy; v.arp_d = ad; v.ip_rdy = irdy; v.ip_d = id; v.exp = e;
        vq.push_back(v);
    endtask

    initial begin
        int   n;
        int   high;
        bit   ack_seen;
        out_t idle_o;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_inputs();
        idle_o = mk(0, 0, 0, 0, 8'h00, 16'h0800);

        // Tie after reset: ARP, IP, ARP, each with the 12-cycle gap between.
        add(1,  1, 1, 0, 0, 0, 8'h00, 0, 8'h00, idle_o);
        add(1,  1, 1, 0, 0, 0, 8'h00, 0, 8'h00, mk(1, 0, 0, 0, 8'h00, 16'h0806));
        add(1,  1, 1, 1, 0, 0, 8'h00, 0, 8'h00, mk(1, 0, 0, 0, 8'h00, 16'h0806));
        add(1,  1, 1, 0, 0, 1, 8'hA5, 1, 8'h11, mk(0, 1, 0, 1, 8'hA5, 16'h0806));
        add(1,  1, 1, 0, 1, 1, 8'h5A, 0, 8'h00, mk(0, 1, 0, 1, 8'h5A, 16'h0806));
        add(13, 1, 1, 0, 0, 0, 8'h00, 0, 8'h00, idle_o);
        add(1,  1, 1, 1, 0, 0, 8'h00, 0, 8'h00, mk(1, 0, 0, 0, 8'h00, 16'h0800));
        add(1,  1, 1, 0, 0, 1, 8'hFF, 1, 8'h3C, mk(0, 0, 1, 1, 8'h3C, 16'h0800));
        add(1,  1, 1, 0, 1, 0, 8'h00, 0, 8'h00, mk(0, 0, 1, 0, 8'h00, 16'h0800));
        add(13, 1, 1, 0, 0, 0, 8'h00, 0, 8'h00, idle_o);
        add(1,  1, 1, 1, 0, 0, 8'h00, 0, 8'h00, mk(1, 0, 0, 0, 8'h00, 16'h0806));
        add(1,  1, 1, 0, 1, 1, 8'hC3, 0, 8'h00, mk(0, 1, 0, 1, 8'hC3, 16'h0806));
        add(1,  0, 0, 0, 0, 0, 8'h00, 0, 8'h00, idle_o);

        // Reset values and table.
        do_reset();
        chk("reset_outputs", 32'(cur_out()), 32'(idle_o));
        foreach (vq[vi]) begin
            for (int r = 0; r < vq[vi].rep; r++) begin
                bus.arp_tx_req   = vq[vi].arp_req;
                bus.ip_tx_req    = vq[vi].ip_req;
                bus.mac_tx_ack   = vq[vi].ack;
                bus.mac_send_end = vq[vi].send_end;
                bus.arp_tx_ready = vq[vi].arp_rdy;
                bus.arp_tx_data  = vq[vi].arp_d;
                bus.ip_tx_ready  = vq[vi].ip_rdy;
                bus.ip_tx_data   = vq[vi].ip_d;
                tick();
                chk($sformatf("table_row%0d_rep%0d", vi, r), 32'(cur_out()), 32'(vq[vi].exp));
            end
        end

        // Single 64-byte IP frame, mac_tx_ack 3 cycles after mac_tx_req.
        do_reset();
        bus.ip_tx_req = 1;
        wait_req(n);
        chk("ip_req_latency", 32'(n), 32'd2);
        chk("ip_wait_ftype", 32'(bus.mac_frame_type), 32'h0800);
        tick();
        tick();
        bus.mac_tx_ack = 1;
        tick();
        bus.mac_tx_ack = 0;
        wait_ack(1, n);
        chk("ip_ack_latency", 32'(n), 32'd1);
        for (int i = 0; i < 64; i++) begin
            bus.ip_tx_ready = 1;
            bus.ip_tx_data  = 8'(i);
            tick();
            chk($sformatf("ip_byte%0d", i), 32'({bus.mac_tx_ready, bus.mac_tx_data, bus.mac_frame_type}),
                32'({1'b1, 8'(i), 16'h0800}));
        end
        bus.ip_tx_ready  = 0;
        bus.ip_tx_data   = 8'h00;
        bus.mac_send_end = 1;
        bus.ip_tx_req    = 0;
        tick();
        bus.mac_send_end = 0;
        chk("ip_ack_end_plus1", 32'(bus.ip_tx_ack), 32'd1);
        tick();
        chk("ip_ack_end_plus2", 32'(bus.ip_tx_ack), 32'd0);

        // Inter-frame gap: IP request raised with the ARP end pulse.
        do_reset();
        bus.arp_tx_req = 1;
        wait_req(n);
        chk("ifg_arp_req", 32'(n), 32'd2);
        bus.mac_tx_ack = 1;
        tick();
        bus.mac_tx_ack = 0;
        wait_ack(0, n);
        chk("ifg_arp_ack", 32'(n), 32'd1);
        bus.arp_tx_req   = 0;
        bus.mac_send_end = 1;
        bus.ip_tx_req    = 1;
        tick();
        bus.mac_send_end = 0;
        wait_req(n);
        chk("ifg_req_after_end", 32'(n), 32'd14);
        chk("ifg_ip_ftype", 32'(bus.mac_frame_type), 32'h0800);

        // Watchdog: no mac_tx_ack ever; request drops right after grant.
        do_reset();
        bus.ip_tx_req = 1;
        wait_req(n);
        chk("wd_req_latency", 32'(n), 32'd2);
        bus.ip_tx_req = 0;
        high = 1;
        ack_seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.ip_tx_ack || bus.arp_tx_ack) ack_seen = 1;
            if (!bus.mac_tx_req) break;
            high++;
        end
        chk("wd_req_high_cycles", 32'(high), 32'd100);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ip_tx_ack || bus.arp_tx_ack || bus.mac_tx_req) ack_seen = 1;
        end
        chk("wd_no_ack", 32'(ack_seen), 32'd0);

        // Reset in the IP data phase, then a normal ARP frame.
        do_reset();
        bus.ip_tx_req = 1;
        wait_req(n);
        bus.mac_tx_ack = 1;
        tick();
        bus.mac_tx_ack = 0;
        wait_ack(1, n);
        chk("rst_ip_ack", 32'(n), 32'd1);
        bus.ip_tx_ready = 1;
        bus.ip_tx_data  = 8'h77;
        tick();
        chk("rst_pre_data", 32'(cur_out()), 32'(mk(0, 0, 1, 1, 8'h77, 16'h0800)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 32'(cur_out()), 32'(idle_o));
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        bus.arp_tx_req = 1;
        wait_req(n);
        chk("post_rst_req_latency", 32'(n), 32'd2);
        chk("post_rst_ftype", 32'(bus.mac_frame_type), 32'h0806);
        bus.mac_tx_ack = 1;
        tick();
        bus.mac_tx_ack = 0;
        bus.arp_tx_ready = 1;
        bus.arp_tx_data  = 8'h42;
        tick();
        chk("post_rst_data", 32'(cur_out()), 32'(mk(0, 1, 0, 1, 8'h42, 16'h0806)));
        bus.arp_tx_ready = 0;
        bus.arp_tx_req   = 0;
        bus.mac_send_end = 1;
        tick();
        bus.mac_send_end = 0;
        tick();
        chk("post_rst_end", 32'(cur_out()), 32'(idle_o));

        // Requester drops req mid-frame; grant holds until mac_send_end.
        do_reset();
        bus.ip_tx_req = 1;
        wait_req(n);
        bus.mac_tx_ack = 1;
        tick();
        bus.mac_tx_ack = 0;
        wait_ack(1, n);
        chk("drop_ack_latency", 32'(n), 32'd1);
        bus.ip_tx_req = 0;
        high = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ip_tx_ack) high++;
        end
        chk("drop_ack_held", 32'(high), 32'd5);
        bus.mac_send_end = 1;
        tick();
        bus.mac_send_end = 0;
        chk("drop_ack_end_plus1", 32'(bus.ip_tx_ack), 32'd1);
        tick();
        chk("drop_ack_end_plus2", 32'(bus.ip_tx_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
